// File: rtl/sample_collector_if.sv
// Host register bus shared with the pin controllers: 21-bit address, 16-bit data,
// single-cycle read/write strobes and registered read data.
interface sample_collector_if;
  logic [20:0] addr;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;

  modport master (output addr, data_in, wr_en, rd_en, input data_out);
  modport slave  (input addr, data_in, wr_en, rd_en, output data_out);
endinterface

// File: rtl/sample_collector.sv
// Pin sample collector: ticks at a programmable rate, pushes synchronised pin words into a FIFO
// drained over the register bus. Optional macro SAMPLE_COLLECTOR_TIMESTAMP_EN adds per-entry timestamps.
module sample_collector #(
  parameter logic [20:0] BASE_ADDR  = 21'd64,
  parameter int          FIFO_DEPTH = 64,
  parameter int          NUM_PINS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  sample_collector_if.slave   bus,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic                fifo_not_empty,
  output logic                capture_done
);
  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
  localparam int ENTRY_W = 2 * DATA_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  logic [DATA_W-1:0]   sample_div, sample_count, div_cnt, taken_cnt, taken_next;
  logic                overflow;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      level;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head, entry;
  logic [NUM_PINS-1:0] pin_sync_p0, pin_sync_p1;
  logic [DATA_W-1:0]   data_out_r, status, tstamp_rd;
  logic [20:0]         offset;
  logic [2:0]          reg_sel;
  logic                in_range, wr_hit, rd_hit;
  logic                start, stop, clr, div_wr, cnt_wr, data_rd;
  logic                empty, full, tick, push, pop;

  function automatic logic [DATA_W-1:0] pack_pins(input logic [NUM_PINS-1:0] p);
    logic [DATA_W-1:0] w;
    w = '0;
    w[NUM_PINS-1:0] = p;
    return w;
  endfunction

  assign offset   = bus.addr - BASE_ADDR;
  assign reg_sel  = offset[2:0];
  assign in_range = (bus.addr >= BASE_ADDR) && (offset[20:3] == '0) && (reg_sel != 3'd7);
  assign wr_hit   = bus.wr_en && in_range;
  assign rd_hit   = bus.rd_en && in_range;
  assign start    = wr_hit && (reg_sel == 3'd0) && bus.data_in[0];
  assign stop     = wr_hit && (reg_sel == 3'd0) && bus.data_in[1];
  assign clr      = wr_hit && (reg_sel == 3'd0) && bus.data_in[2];
  assign div_wr   = wr_hit && (reg_sel == 3'd1);
  assign cnt_wr   = wr_hit && (reg_sel == 3'd2);
  assign data_rd  = rd_hit && (reg_sel == 3'd5);

  assign empty      = (level == '0);
  assign full       = (level == DEPTH_L);
  assign taken_next = taken_cnt + 16'd1;
  // A control write in the same cycle as a tick wins; the tick is not taken.
  assign tick = (state == RUN) && (div_cnt == '0) && !start && !stop && !clr;
  assign pop  = data_rd && !empty && !clr;
  assign push = tick && (!full || pop);

  assign head   = mem[rd_ptr];
  assign status = {11'd0, state, overflow, full, empty};
  assign fifo_not_empty = !empty;
  assign bus.data_out   = data_out_r;

`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
  logic [DATA_W-1:0] tstamp;
  assign entry     = {tstamp, pack_pins(pin_sync_p1)};
  assign tstamp_rd = empty ? '0 : head[ENTRY_W-1:DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      tstamp <= '0;
    else if (start) tstamp <= '0;
    else            tstamp <= tstamp + 16'd1;
  end
`else
  assign entry     = pack_pins(pin_sync_p1);
  assign tstamp_rd = '0;
`endif

  // Stage p0/p1: two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk) begin
    pin_sync_p0 <= pin_in;
    pin_sync_p1 <= pin_sync_p0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sample_div   <= '0;
      sample_count <= '0;
      div_cnt      <= '0;
      taken_cnt    <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      capture_done <= 1'b0;
      data_out_r   <= '0;
    end else begin
      capture_done <= 1'b0;
      if (div_wr) sample_div   <= bus.data_in;
      if (cnt_wr) sample_count <= bus.data_in;

      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
        if (tick && full && !pop) overflow <= 1'b1;
      end

      // CLEAR has already emptied the FIFO above, so START here restarts on a clean buffer.
      if (start) begin
        state     <= RUN;
        div_cnt   <= sample_div;
        taken_cnt <= '0;
      end else if (clr || stop) begin
        state <= IDLE;
      end else if (tick) begin
        div_cnt   <= sample_div;
        taken_cnt <= taken_next;
        if ((sample_count != '0) && (taken_next == sample_count)) begin
          state        <= DONE;
          capture_done <= 1'b1;
        end
      end else if (state == RUN) begin
        div_cnt <= div_cnt - 16'd1;
      end

      if (rd_hit) begin
        case (reg_sel)
          3'd0:    data_out_r <= '0;
          3'd1:    data_out_r <= sample_div;
          3'd2:    data_out_r <= sample_count;
          3'd3:    data_out_r <= status;
          3'd4:    data_out_r <= DATA_W'(level);
          3'd5:    data_out_r <= empty ? '0 : head[DATA_W-1:0];
          3'd6:    data_out_r <= tstamp_rd;
          default: data_out_r <= data_out_r;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector (FIFO_DEPTH=8) with a queue scoreboard of expected FIFO words.
module tb_sample_collector;
  localparam logic [20:0] BASE    = 21'd64;
  localparam logic [20:0] A_CTRL  = BASE;
  localparam logic [20:0] A_DIV   = BASE + 21'd1;
  localparam logic [20:0] A_CNT   = BASE + 21'd2;
  localparam logic [20:0] A_STAT  = BASE + 21'd3;
  localparam logic [20:0] A_LEVEL = BASE + 21'd4;
  localparam logic [20:0] A_DATA  = BASE + 21'd5;
  localparam logic [20:0] A_TS    = BASE + 21'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pin_in;
  logic        fifo_not_empty;
  logic        capture_done;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];

  sample_collector_if bus();

  sample_collector #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .NUM_PINS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .pin_in         (pin_in),
    .fifo_not_empty (fifo_not_empty),
    .capture_done   (capture_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [20:0] a, input logic [15:0] d);
    bus.addr = a; bus.data_in = d; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [20:0] a, output logic [15:0] d);
    bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.data_out;
  endtask

  task automatic rd_chk(input string tag, input logic [20:0] a, input logic [15:0] exp);
    logic [15:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] d;
    logic [15:0] e;
    rd(A_DATA, d);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed %h expected nothing (scoreboard empty)", tag, d);
    end else begin
      e = exp_q.pop_front();
      check(tag, d, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first_push, done_pulses, done_at;
    logic [15:0] t1, t2;
    bus.addr = '0; bus.data_in = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    pin_in = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_not_empty", {15'd0, fifo_not_empty}, 16'h0000);
    check("rst_capture_done", {15'd0, capture_done}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_status", A_STAT, 16'h0001);
    rd_chk("rst_level", A_LEVEL, 16'h0000);
    rd_chk("empty_data_read", A_DATA, 16'h0000);
    rd_chk("empty_tstamp", A_TS, 16'h0000);
    rd_chk("status_again", A_STAT, 16'h0001);
    rd_chk("unmapped_hi_keeps", BASE + 21'd7, 16'h0001);
    rd_chk("unmapped_lo_keeps", BASE - 21'd1, 16'h0001);

    // One-shot: DIV=3, COUNT=4
    pin_in = 16'hA5A5;
    wr(A_DIV, 16'd3);
    wr(A_CNT, 16'd4);
    rd_chk("div_readback", A_DIV, 16'd3);
    rd_chk("ctrl_reads_zero", A_CTRL, 16'h0000);
    wr(A_CTRL, 16'h0001);
    repeat (4) exp_q.push_back(16'hA5A5);
    first_push = -1; done_pulses = 0; done_at = -1;
    for (int k = 0; k < 24; k++) begin
      if (fifo_not_empty && first_push < 0) first_push = k;
      if (capture_done) begin
        done_pulses++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    check("first_push_latency", 16'(first_push), 16'd4);
    check("capture_done_pulses", 16'(done_pulses), 16'd1);
    check("capture_done_cycle", 16'(done_at), 16'd16);
    rd_chk("oneshot_status_done", A_STAT, 16'h0010);
    rd_chk("oneshot_level", A_LEVEL, 16'd4);
    repeat (4) pop_chk("oneshot_data");
    rd_chk("oneshot_status_empty", A_STAT, 16'h0011);

    // Continuous overflow: DIV=0, COUNT=0, no reads for 12 cycles
    pin_in = 16'h20FF;
    wr(A_DIV, 16'd0);
    wr(A_CNT, 16'd0);
    wr(A_CTRL, 16'h0001);
    exp_q.push_back(16'h20FF);
    exp_q.push_back(16'h20FF);
    for (int k = 0; k < 6; k++) exp_q.push_back(16'h2000 + 16'(k));
    for (int k = 0; k < 12; k++) begin
      pin_in = 16'h2000 + 16'(k);
      @(negedge clk);
    end
    rd_chk("ovf_level", A_LEVEL, 16'd8);
    rd_chk("ovf_status", A_STAT, 16'h000E);
    pop_chk("ovf_first_sample");
    wr(A_CTRL, 16'h0004);
    exp_q.delete();
    check("clear_not_empty", {15'd0, fifo_not_empty}, 16'h0000);
    rd_chk("clear_level", A_LEVEL, 16'd0);
    rd_chk("clear_status", A_STAT, 16'h0001);

    // Full FIFO with a DATA read on the 9th tick: DIV=3, COUNT=9
    wr(A_DIV, 16'd3);
    wr(A_CNT, 16'd9);
    wr(A_CTRL, 16'h0001);
    for (int j = 1; j <= 8; j++) begin
      pin_in = 16'h3000 + 16'(j);
      exp_q.push_back(pin_in);
      repeat (4) @(negedge clk);
    end
    pin_in = 16'h3009;
    repeat (3) @(negedge clk);
    pop_chk("full_pop_with_push");
    exp_q.push_back(16'h3009);
    rd_chk("full_pop_level", A_LEVEL, 16'd8);
    rd_chk("full_pop_status", A_STAT, 16'h0012);
    repeat (8) pop_chk("full_drain");
    check("full_drain_empty", {15'd0, fifo_not_empty}, 16'h0000);

    // Synchroniser latency: pin changes 1 cycle before the second tick
    pin_in = 16'h0001;
    wr(A_DIV, 16'd0);
    wr(A_CNT, 16'd3);
    wr(A_CTRL, 16'h0001);
    pin_in = 16'h0002;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    repeat (4) @(negedge clk);
    repeat (3) pop_chk("sync_latency");

    // Reset in the middle of a run with LEVEL=3
    wr(A_CTRL, 16'h0001);
    repeat (4) @(negedge clk);
    rd_chk("pre_reset_level", A_LEVEL, 16'd3);
    wr(A_DIV, 16'd7);
    wr(A_CNT, 16'd0);
    wr(A_CTRL, 16'h0001);
    repeat (2) @(negedge clk);
    check("pre_reset_not_empty", {15'd0, fifo_not_empty}, 16'h0001);
    reset = 1'b1;
    #1;
    check("async_rst_not_empty", {15'd0, fifo_not_empty}, 16'h0000);
    check("async_rst_data_out", bus.data_out, 16'h0000);
    check("async_rst_capture_done", {15'd0, capture_done}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("post_rst_status", A_STAT, 16'h0001);
    rd_chk("post_rst_level", A_LEVEL, 16'd0);
    rd_chk("post_rst_div", A_DIV, 16'd0);

`ifdef SAMPLE_COLLECTOR_TIMESTAMP_EN
    // Timestamps: DIV=9 gives entries stamped 9, 19, 29
    pin_in = 16'h0042;
    wr(A_DIV, 16'd9);
    wr(A_CNT, 16'd3);
    wr(A_CTRL, 16'h0001);
    repeat (3) exp_q.push_back(16'h0042);
    repeat (32) @(negedge clk);
    rd(A_TS, t1);
    check("ts_first", t1, 16'd9);
    pop_chk("ts_data");
    rd(A_TS, t2);
    check("ts_delta", t2 - t1, 16'd10);
    pop_chk("ts_data");
    rd_chk("ts_third", A_TS, 16'd29);
    pop_chk("ts_data");
    rd_chk("ts_empty", A_TS, 16'd0);
`else
    // No timestamps: TSTAMP reads 0 even with data queued
    pin_in = 16'h0042;
    wr(A_DIV, 16'd1);
    wr(A_CNT, 16'd2);
    wr(A_CTRL, 16'h0001);
    repeat (2) exp_q.push_back(16'h0042);
    repeat (6) @(negedge clk);
    check("nots_not_empty", {15'd0, fifo_not_empty}, 16'h0001);
    rd(A_TS, t1);
    check("nots_tstamp_zero", t1, 16'd0);
    rd(A_LEVEL, t2);
    check("nots_tstamp_no_pop", t2, 16'd2);
    repeat (2) pop_chk("nots_data");
`endif
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sample_collector.md
Name: sample_collector

Overview:
- Downstream consumer of the per-pin controllers. Captures the input levels of up to 16 pins on a programmable sample tick and buffers the packed words in an internal FIFO.
- The host drains the FIFO over the same 21-bit address / 16-bit data register bus that programs the pin controllers.
- Provides a one-shot mode (capture N samples, then stop) and a continuous mode, with overflow detection.

Parameters:
- BASE_ADDR, 21'd64: first register address of this block; occupies BASE_ADDR..BASE_ADDR+6.
- FIFO_DEPTH, 64: number of FIFO entries; must be a power of two, 4 to 1024.
- NUM_PINS, 16: active pin inputs, 1 to 16; unused upper bits of a sample word read 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  21  register address
- data_in  in  16  write data
- wr_en  in  1  write strobe; one write per cycle
- rd_en  in  1  read strobe; one read per cycle
- data_out  out  16  registered read data
- pin_in  in  NUM_PINS  raw pin levels, asynchronous to clk
- fifo_not_empty  out  1  level flag for host polling or interrupt
- capture_done  out  1  one-cycle pulse when a one-shot capture completes

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, FIFO empty, all registers 0.
- Register map, offsets from BASE_ADDR:
  - +0 CTRL (write-only, self-clearing). bit0 START, bit1 STOP, bit2 CLEAR. Reads 0.
  - +1 SAMPLE_DIV (R/W). Sample period = SAMPLE_DIV+1 clk cycles.
  - +2 SAMPLE_COUNT (R/W). Samples to take in one-shot mode; 0 selects continuous mode.
  - +3 STATUS (RO). bit0 empty, bit1 full, bit2 overflow (sticky), bits[4:3] state (IDLE=0, RUN=1, DONE=2).
  - +4 LEVEL (RO). FIFO fill level, 0..FIFO_DEPTH.
  - +5 DATA (RO). Returns the FIFO head and pops it. Reading while empty returns 0 and does not pop.
  - +6 TSTAMP (RO). See Optional Feature.
- Reads: data_out is valid the cycle after rd_en and holds until the next read. Writes take effect the cycle after wr_en. Unmapped addresses are ignored and leave data_out unchanged.
- Synchroniser: pin_in passes through a 2-flop synchroniser. Each sample reflects pin state from 2 cycles before the sample tick.
- State machine:
  - IDLE: on START, go to RUN; load div_cnt from SAMPLE_DIV; clear taken_cnt.
  - RUN: div_cnt decrements each cycle. At 0, take a sample (push the synchronised pins, zero-extended to 16 bits), reload div_cnt, and increment taken_cnt (16-bit).
    - If SAMPLE_COUNT != 0 and taken_cnt reaches SAMPLE_COUNT: go to DONE and pulse capture_done.
    - STOP: go to IDLE with no further samples; FIFO contents are kept.
    - START while in RUN: restart; reload div_cnt and clear taken_cnt. FIFO contents are kept.
  - DONE: START behaves as from IDLE. STOP goes to IDLE.
- Sample timing: with SAMPLE_DIV=0, one sample per cycle. The first sample is taken SAMPLE_DIV+1 cycles after the START write takes effect.
- CLEAR: empties the FIFO, clears overflow, and returns to IDLE. If START and CLEAR are set in the same write, CLEAR is applied first, then START.
- FIFO rules:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full or empty. A push to an empty FIFO is not readable in that same cycle.
  - A push while full with no simultaneous pop drops the sample and sets overflow. The dropped sample still counts toward SAMPLE_COUNT.
  - Pointers wrap modulo FIFO_DEPTH.
- Register writes during RUN:
  - SAMPLE_DIV: takes effect at the next reload.
  - SAMPLE_COUNT: compared live. If the new value is at or below taken_cnt, capture continues until taken_cnt wraps around to match it.
- Reset mid-capture: immediate return to IDLE; FIFO contents are lost.

Optional Feature:
- Macro: SAMPLE_COLLECTOR_TIMESTAMP_EN.
- With the macro defined:
  - A 16-bit free-running tick counter is cleared on each START and increments every clk; it wraps at 16'hFFFF.
  - Each FIFO entry stores {timestamp, pins}.
  - TSTAMP (+6) returns the head entry's timestamp without popping. Read TSTAMP before DATA.
  - When the FIFO is empty, TSTAMP reads 0.
- Without the macro: FIFO entries are 16 bits wide, and TSTAMP always reads 0.

Test Plan:
- SAMPLE_DIV=3, SAMPLE_COUNT=4, pin_in=16'hA5A5, START -> 4 pushes spaced 4 cycles apart; first push 4 cycles after START takes effect; capture_done pulses once; STATUS state=DONE; LEVEL=4; four DATA reads return 16'hA5A5, then empty=1.
- FIFO_DEPTH=8, SAMPLE_DIV=0, SAMPLE_COUNT=0, START, no reads for 12 cycles -> LEVEL=8, full=1, overflow=1; first DATA read returns the first sample; CLEAR then gives LEVEL=0, overflow=0, state=IDLE.
- Full FIFO, DATA read coinciding with a sample tick -> both succeed; LEVEL stays 8; overflow not set.
- pin_in toggles 0x0001 to 0x0002 exactly 1 cycle before a tick, SAMPLE_DIV=0 -> that sample reads 0x0001 (synchroniser latency); next sample reads 0x0002.
- Assert reset 2 cycles into RUN with LEVEL=3 -> immediately state=IDLE, LEVEL=0, data_out=0, fifo_not_empty=0.
- Timestamp build, SAMPLE_DIV=9, START -> TSTAMP of successive entries differs by 10; DATA pops, and the next TSTAMP read shows the following entry.
